// File: rtl/hazard_ctrl_v2.sv
// Pipeline hazard controller for a 5-stage F/D/E/M/W core: per-stage stall/bubble,
// multi-cycle EX/LSU holds, optional no-bypass mode, fetch-drop FSM and perf counters.
module hazard_ctrl_v2 #(
  parameter int RW     = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    dec_rs1,
  input  logic [RW-1:0]    dec_rs2,
  input  logic             dec_rs1_use,
  input  logic             dec_rs2_use,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_wen,
  input  logic             ex_redirect,
  input  logic             ex_busy,
  input  logic             lsu_busy,
  input  logic             ifu_valid,
  input  logic             ifu_busy,
  input  logic             perf_clr,
  output logic [4:0]       stall,
  output logic [4:0]       bubble,
  output logic             drop_fetch,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, DROP} state_t;

  state_t state, state_nxt;
  logic   hit_ex, hit_mem, lu, redir;

  // x0 is hardwired zero, so a write to it can never create a dependency.
  assign hit_ex  = (ex_rd != '0) &&
                   ((dec_rs1_use && dec_rs1 == ex_rd) || (dec_rs2_use && dec_rs2 == ex_rd));
  assign hit_mem = (mem_rd != '0) &&
                   ((dec_rs1_use && dec_rs1 == mem_rd) || (dec_rs2_use && dec_rs2 == mem_rd));

  assign lu    = FWD_EN ? (ex_wen && ex_is_load && hit_ex)
                        : ((ex_wen && hit_ex) || (mem_wen && hit_mem));
  assign redir = ex_redirect && !ex_busy && !lsu_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A redirect while a fetch is still in flight means the late response belongs to the
  // wrong path; DROP waits for it and discards it.
  always_comb begin
    // NOTE: defaulting every comb output first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      IDLE: if (redir && ifu_busy) state_nxt = DROP;
      DROP: if (redir && ifu_busy) state_nxt = DROP;
            else if (ifu_valid)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall      = '0;
    bubble     = '0;
    drop_fetch = (state == DROP) && ifu_valid;
    if (lsu_busy) begin
      stall  = 5'b01111;
      bubble = 5'b10000;
    end else if (ex_busy) begin
      stall  = 5'b00111;
      bubble = 5'b01000;
    end else if (redir) begin
      bubble = 5'b00110;
    end else if (lu) begin
      stall  = 5'b00011;
      bubble = 5'b00100;
    end
    // D loads a NOP whenever it advances without a usable instruction.
    if (!stall[1] && (!ifu_valid || drop_fetch)) bubble[1] = 1'b1;
    if (rst) begin
      stall      = '0;
      bubble     = '1;
      drop_fetch = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall[0] && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir && flush_cnt != '1)    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Self-checking bench for hazard_ctrl_v2: bypass, no-bypass and 4-bit-counter instances
// share one stimulus; vector table plus hand sequences for FSM, counters and reset.
module tb_hazard_ctrl_v2;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] ex_rd;
    logic       ex_wen, ex_load;
    logic [4:0] mem_rd;
    logic       mem_wen;
    logic       redirect, exb, lsub, iv, ib;
    logic [4:0] st1, bu1, st0, bu0;
  } vec_t;

  logic clk, rst;
  logic [4:0] dec_rs1, dec_rs2, ex_rd, mem_rd;
  logic dec_rs1_use, dec_rs2_use, ex_wen, ex_is_load, mem_wen;
  logic ex_redirect, ex_busy, lsu_busy, ifu_valid, ifu_busy, perf_clr;

  logic [4:0]  stall_f1, bubble_f1, stall_f0, bubble_f0, stall_c4, bubble_c4;
  logic        drop_f1, drop_f0, drop_c4;
  logic [15:0] scnt_f1, fcnt_f1, scnt_f0, fcnt_f0;
  logic [3:0]  scnt_c4, fcnt_c4;

  int total = 0;
  int bad   = 0;

  vec_t tbl [0:10];
  vec_t sb [$];

  hazard_ctrl_v2 #(.RW(5), .FWD_EN(1'b1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst(rst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .ex_redirect(ex_redirect),
    .ex_busy(ex_busy), .lsu_busy(lsu_busy), .ifu_valid(ifu_valid), .ifu_busy(ifu_busy),
    .perf_clr(perf_clr), .stall(stall_f1), .bubble(bubble_f1), .drop_fetch(drop_f1),
    .stall_cnt(scnt_f1), .flush_cnt(fcnt_f1));

  hazard_ctrl_v2 #(.RW(5), .FWD_EN(1'b0), .CNT_W(16)) u_f0 (
    .clk(clk), .rst(rst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .ex_redirect(ex_redirect),
    .ex_busy(ex_busy), .lsu_busy(lsu_busy), .ifu_valid(ifu_valid), .ifu_busy(ifu_busy),
    .perf_clr(perf_clr), .stall(stall_f0), .bubble(bubble_f0), .drop_fetch(drop_f0),
    .stall_cnt(scnt_f0), .flush_cnt(fcnt_f0));

  hazard_ctrl_v2 #(.RW(5), .FWD_EN(1'b1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen), .ex_redirect(ex_redirect),
    .ex_busy(ex_busy), .lsu_busy(lsu_busy), .ifu_valid(ifu_valid), .ifu_busy(ifu_busy),
    .perf_clr(perf_clr), .stall(stall_c4), .bubble(bubble_c4), .drop_fetch(drop_c4),
    .stall_cnt(scnt_c4), .flush_cnt(fcnt_c4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    dec_rs1 = v.rs1;   dec_rs2 = v.rs2;   dec_rs1_use = v.use1; dec_rs2_use = v.use2;
    ex_rd   = v.ex_rd; ex_wen  = v.ex_wen; ex_is_load = v.ex_load;
    mem_rd  = v.mem_rd; mem_wen = v.mem_wen;
    ex_redirect = v.redirect; ex_busy = v.exb; lsu_busy = v.lsub;
    ifu_valid = v.iv; ifu_busy = v.ib;
  endtask

  function automatic vec_t quiet();
    vec_t v;
    v = '{"quiet", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00};
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    apply(v);
  endtask

  task automatic chk_f1(input string name, input logic [4:0] st, input logic [4:0] bu,
                        input logic dr);
    check({name, ".stall"},  32'(stall_f1),  32'(st));
    check({name, ".bubble"}, 32'(bubble_f1), 32'(bu));
    check({name, ".drop"},   32'(drop_f1),   32'(dr));
  endtask

  initial begin
    vec_t v, e;

    //        name         rs1 rs2 u1 u2 exrd ewen eld mrd mwen red exb lsb iv ib  st1    bu1    st0    bu0
    tbl[0]  = '{"lu_rs2",    0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 5'h03, 5'h04, 5'h03, 5'h04};
    tbl[1]  = '{"lu_rd0",    0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 5'h00};
    tbl[2]  = '{"store",     0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 5'h03, 5'h04};
    tbl[3]  = '{"mem_raw",   7, 0, 1, 0, 2, 1, 0, 7, 1, 0, 0, 0, 1, 0, 5'h00, 5'h00, 5'h03, 5'h04};
    tbl[4]  = '{"no_use",    7, 7, 0, 0, 7, 1, 1, 7, 1, 0, 0, 0, 1, 0, 5'h00, 5'h00, 5'h00, 5'h00};
    tbl[5]  = '{"d_fill",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 5'h02, 5'h00, 5'h02};
    tbl[6]  = '{"lu_nofill", 0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'h03, 5'h04, 5'h03, 5'h04};
    tbl[7]  = '{"ex_busy",   0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 1, 0, 1, 0, 5'h07, 5'h08, 5'h07, 5'h08};
    tbl[8]  = '{"lsu_busy",  0, 5, 0, 1, 5, 1, 1, 0, 0, 1, 1, 1, 0, 0, 5'h0f, 5'h10, 5'h0f, 5'h10};
    tbl[9]  = '{"redir_lu",  0, 5, 0, 1, 5, 1, 1, 0, 0, 1, 0, 0, 1, 0, 5'h00, 5'h06, 5'h00, 5'h06};
    tbl[10] = '{"redir_exb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 5'h07, 5'h08, 5'h07, 5'h08};

    rst = 1'b1;
    perf_clr = 1'b0;
    apply(quiet());
    @(negedge clk);
    check("rst.stall",  32'(stall_f1),  32'h00);
    check("rst.bubble", 32'(bubble_f1), 32'h1f);
    check("rst.drop",   32'(drop_f1),   32'h0);
    check("rst.scnt",   32'(scnt_f1),   32'h0);
    check("rst.fcnt",   32'(fcnt_f1),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Combinational vectors; none enters DROP since ifu_busy stays low.
    for (int i = 0; i <= 10; i++) begin
      step(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      check({e.name, ".f1.stall"},  32'(stall_f1),  32'(e.st1));
      check({e.name, ".f1.bubble"}, 32'(bubble_f1), 32'(e.bu1));
      check({e.name, ".f0.stall"},  32'(stall_f0),  32'(e.st0));
      check({e.name, ".f0.bubble"}, 32'(bubble_f0), 32'(e.bu0));
      check({e.name, ".drop"},      32'(drop_f1),   32'h0);
    end

    // Clear counters, then redirect with fetch outstanding.
    v = quiet(); step(v); perf_clr = 1'b1;
    @(posedge clk); #1; perf_clr = 1'b0;
    check("clr.fcnt", 32'(fcnt_f1), 32'h0);
    check("clr.scnt", 32'(scnt_f1), 32'h0);
    v = quiet(); v.redirect = 1; v.ib = 1; v.iv = 0; apply(v);
    @(negedge clk); chk_f1("redir_busy", 5'h00, 5'h06, 1'b0);
    v = quiet(); step(v);
    @(negedge clk); chk_f1("drop_rsp", 5'h00, 5'h02, 1'b1);
    check("drop_rsp.fcnt", 32'(fcnt_f1), 32'h1);
    v = quiet(); step(v);
    @(negedge clk); chk_f1("after_drop", 5'h00, 5'h00, 1'b0);

    // Redirect in DROP with a response and another fetch pending keeps dropping.
    v = quiet(); v.redirect = 1; v.ib = 1; v.iv = 0; step(v);
    v = quiet(); v.redirect = 1; v.ib = 1; v.iv = 1; step(v);
    @(negedge clk); chk_f1("redrop", 5'h00, 5'h06, 1'b1);
    v = quiet(); step(v);
    @(negedge clk); chk_f1("redrop2", 5'h00, 5'h02, 1'b1);
    v = quiet(); step(v);
    @(negedge clk); chk_f1("redrop_idle", 5'h00, 5'h00, 1'b0);
    check("redrop.fcnt", 32'(fcnt_f1), 32'h3);

    // LSU wait masks redirect and load-use for 3 cycles.
    v = tbl[0]; v.redirect = 1; v.lsub = 1;
    for (int i = 0; i < 3; i++) begin
      step(v);
      @(negedge clk); chk_f1($sformatf("lsu_hold%0d", i), 5'h0f, 5'h10, 1'b0);
    end
    check("lsu_hold.fcnt", 32'(fcnt_f1), 32'h3);
    v.lsub = 0; step(v);
    @(negedge clk); chk_f1("lsu_release", 5'h00, 5'h06, 1'b0);
    v = quiet(); step(v);
    check("lsu_release.fcnt", 32'(fcnt_f1), 32'h4);

    // Stall counting and saturation of the 4-bit instance.
    perf_clr = 1'b1;
    v = quiet(); v.exb = 1; step(v); perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) step(v);
    @(negedge clk); chk_f1("exb_hold", 5'h07, 5'h08, 1'b0);
    v = quiet(); step(v);
    check("exb4.scnt", 32'(scnt_f1), 32'd4);
    check("exb4.c4",   32'(scnt_c4), 32'd4);
    v.exb = 1;
    for (int i = 0; i < 14; i++) step(v);
    @(posedge clk); #1;
    check("sat.scnt", 32'(scnt_f1), 32'd18);
    check("sat.c4",   32'(scnt_c4), 32'd15);
    perf_clr = 1'b1;
    @(posedge clk); #1; perf_clr = 1'b0;
    check("clr_in_stall.scnt", 32'(scnt_f1), 32'd0);
    check("clr_in_stall.c4",   32'(scnt_c4), 32'd0);

    // Reset asserted mid-DROP.
    v = quiet(); v.redirect = 1; v.ib = 1; v.iv = 0; step(v);
    v = quiet(); step(v);
    #1; check("pre_rst.drop", 32'(drop_f1), 32'h1);
    rst = 1'b1;
    #1;
    chk_f1("mid_rst", 5'h00, 5'h1f, 1'b0);
    check("mid_rst.scnt", 32'(scnt_f1), 32'h0);
    check("mid_rst.fcnt", 32'(fcnt_f1), 32'h0);
    @(negedge clk); @(negedge clk);
    chk_f1("rst_hold", 5'h00, 5'h1f, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk_f1("post_rst", 5'h00, 5'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
